// File: rtl/ddio_ctrl_pkg.sv
// Shared types and width helpers for the DDIO input capture controller.
// Imported by the top level and the output buffer.
package ddio_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        CAPTURE = 2'd2
    } ddio_state_e;

    function automatic int unsigned beat_w(input int unsigned data_width);
        return 2 * data_width;
    endfunction

    function automatic int unsigned word_w(input int unsigned data_width,
                                           input int unsigned word_beats);
        return 2 * data_width * word_beats;
    endfunction

    // Counter width for values 0..v-1; never below one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddio_word_skid_buf.sv
// Two-entry FIFO for assembled words with valid/ready output.
// Head and tail are separate registers so the output is driven straight from flops.
module ddio_word_skid_buf
    import ddio_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_drop_c
);

    logic [WIDTH-1:0] r_head;
    logic             r_head_v;
    logic [WIDTH-1:0] r_tail;
    logic             r_tail_v;
    logic             r_full;

    logic             w_pop;
    logic             w_accept;
    logic [WIDTH-1:0] w_head;
    logic             w_head_v;
    logic [WIDTH-1:0] w_tail;
    logic             w_tail_v;

    // A pop frees a slot in the same cycle, so push+pop is legal even when full.
    assign w_pop    = r_head_v & i_ready;
    assign w_accept = i_push & (~r_full | w_pop);
    assign o_drop_c = i_push & r_full & ~w_pop;

    always_comb begin
        w_head   = r_head;
        w_head_v = r_head_v;
        w_tail   = r_tail;
        w_tail_v = r_tail_v;
        if (w_pop) begin
            w_head   = r_tail;
            w_head_v = r_tail_v;
            w_tail_v = 1'b0;
        end
        if (w_accept) begin
            if (w_head_v) begin
                w_tail   = i_push_data;
                w_tail_v = 1'b1;
            end else begin
                w_head   = i_push_data;
                w_head_v = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head   <= '0;
            r_head_v <= 1'b0;
            r_tail   <= '0;
            r_tail_v <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            r_head   <= w_head;
            r_head_v <= w_head_v;
            r_tail   <= w_tail;
            r_tail_v <= w_tail_v;
            r_full   <= w_head_v & w_tail_v;
        end
    end

    assign o_data  = r_head;
    assign o_valid = r_head_v;
    assign o_full  = r_full;

endmodule

// File: rtl/ddio_in_capture_ctrl.sv
// Sequencer for a bank of DDR input capture atoms: drives clkena, hunts for the
// sync beat, picks normal or half-cycle-swapped edge pairing and assembles words.
module ddio_in_capture_ctrl
    import ddio_ctrl_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH    = 8,
    parameter int unsigned              WORD_BEATS    = 4,
    parameter logic [2*DATA_WIDTH-1:0]  SYNC_PATTERN  = 16'hA55A,
    parameter int unsigned              SYNC_TIMEOUT  = 1024,
    parameter bit                       STALL_ON_FULL = 1'b0
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        enable,
    output logic                                        ddio_clkena,
    input  logic [DATA_WIDTH-1:0]                       ddio_h,
    input  logic [DATA_WIDTH-1:0]                       ddio_l,
    output logic [word_w(DATA_WIDTH, WORD_BEATS)-1:0]   word_data,
    output logic                                        word_valid,
    input  logic                                        word_ready,
    output logic                                        locked,
    output logic                                        swapped,
    output logic                                        timeout,
    output logic                                        overflow
);

    localparam int unsigned BEAT_W = beat_w(DATA_WIDTH);
    localparam int unsigned WORD_W = word_w(DATA_WIDTH, WORD_BEATS);
    localparam int unsigned BCNT_W = clog2(WORD_BEATS);
    localparam int unsigned HCNT_W = clog2(SYNC_TIMEOUT);

    ddio_state_e         r_state;
    ddio_state_e         w_state_nxt;

    logic                r_clkena;
    logic                r_samp_v;
    logic [DATA_WIDTH-1:0] r_prev_l;
    logic                r_prev_l_v;
    logic [HCNT_W-1:0]   r_hunt_cnt;
    logic [BCNT_W-1:0]   r_beat_cnt;
    logic [WORD_W-1:0]   r_word;
    logic                r_locked;
    logic                r_swapped;
    logic                r_timeout;
    logic                r_overflow;

    logic                w_clkena_nxt;
    logic [DATA_WIDTH-1:0] w_prev_l_nxt;
    logic                w_prev_l_v_nxt;
    logic [HCNT_W-1:0]   w_hunt_cnt_nxt;
    logic [BCNT_W-1:0]   w_beat_cnt_nxt;
    logic [WORD_W-1:0]   w_word_nxt;
    logic                w_locked_nxt;
    logic                w_swapped_nxt;
    logic                w_timeout_nxt;
    logic                w_overflow_nxt;

    logic [BEAT_W-1:0]   w_beat_n;
    logic [BEAT_W-1:0]   w_beat_s;
    logic [BEAT_W-1:0]   w_beat;
    logic                w_proc;
    logic                w_match_n;
    logic                w_match_s;
    logic                w_last;
    logic                w_push;
    logic                w_buf_full;
    logic                w_drop_c;

    // Swapped pairing joins this rising-edge sample with the previous falling-edge one.
    assign w_beat_n  = {ddio_l, ddio_h};
    assign w_beat_s  = {ddio_h, r_prev_l};
    assign w_beat    = r_swapped ? w_beat_s : w_beat_n;
    assign w_proc    = r_samp_v & enable & (r_state != IDLE);
    assign w_match_n = (w_beat_n == SYNC_PATTERN);
    assign w_match_s = r_prev_l_v & (w_beat_s == SYNC_PATTERN);
    assign w_last    = (r_beat_cnt == BCNT_W'(WORD_BEATS - 1));
    assign w_push    = w_proc & (r_state == CAPTURE) & w_last;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = HUNT;
                HUNT:    if (w_proc && (w_match_n || w_match_s)) w_state_nxt = CAPTURE;
                CAPTURE: w_state_nxt = CAPTURE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_clkena_nxt   = (w_state_nxt != IDLE);
        w_locked_nxt   = (w_state_nxt == CAPTURE);
        w_swapped_nxt  = r_swapped;
        w_timeout_nxt  = 1'b0;
        w_overflow_nxt = r_overflow | w_drop_c;
        w_prev_l_nxt   = r_prev_l;
        w_prev_l_v_nxt = r_prev_l_v;
        w_hunt_cnt_nxt = r_hunt_cnt;
        w_beat_cnt_nxt = r_beat_cnt;
        w_word_nxt     = r_word;

        if (w_state_nxt == IDLE) begin
            // Leaving the run discards alignment, partial word and the sticky drop flag.
            w_swapped_nxt  = 1'b0;
            w_overflow_nxt = 1'b0;
            w_prev_l_v_nxt = 1'b0;
            w_hunt_cnt_nxt = '0;
            w_beat_cnt_nxt = '0;
        end else if (w_proc) begin
            w_prev_l_nxt   = ddio_l;
            w_prev_l_v_nxt = 1'b1;
            case (r_state)
                HUNT: begin
                    if (w_match_n || w_match_s) begin
                        w_swapped_nxt  = ~w_match_n;
                        w_hunt_cnt_nxt = '0;
                        w_beat_cnt_nxt = '0;
                    end else if (r_hunt_cnt == HCNT_W'(SYNC_TIMEOUT - 1)) begin
                        w_timeout_nxt  = 1'b1;
                        w_hunt_cnt_nxt = '0;
                    end else begin
                        w_hunt_cnt_nxt = r_hunt_cnt + HCNT_W'(1);
                    end
                end
                CAPTURE: begin
                    for (int unsigned b = 0; b < WORD_BEATS; b++) begin
                        if (r_beat_cnt == BCNT_W'(b)) begin
                            w_word_nxt[b*BEAT_W +: BEAT_W] = w_beat;
                        end
                    end
                    w_beat_cnt_nxt = w_last ? '0 : r_beat_cnt + BCNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clkena   <= 1'b0;
            r_samp_v   <= 1'b0;
            r_prev_l   <= '0;
            r_prev_l_v <= 1'b0;
            r_hunt_cnt <= '0;
            r_beat_cnt <= '0;
            r_word     <= '0;
            r_locked   <= 1'b0;
            r_swapped  <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_clkena   <= w_clkena_nxt;
            r_samp_v   <= ddio_clkena;
            r_prev_l   <= w_prev_l_nxt;
            r_prev_l_v <= w_prev_l_v_nxt;
            r_hunt_cnt <= w_hunt_cnt_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_word     <= w_word_nxt;
            r_locked   <= w_locked_nxt;
            r_swapped  <= w_swapped_nxt;
            r_timeout  <= w_timeout_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    ddio_word_skid_buf #(
        .WIDTH (WORD_W)
    ) u_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data (w_word_nxt),
        .i_ready     (word_ready),
        .o_data      (word_data),
        .o_valid     (word_valid),
        .o_full      (w_buf_full),
        .o_drop_c    (w_drop_c)
    );

    // With a flow-controlled source, hold the atoms while no slot can open this cycle.
    assign ddio_clkena = r_clkena & ~(STALL_ON_FULL & w_buf_full & ~word_ready);

    assign locked   = r_locked;
    assign swapped  = r_swapped;
    assign timeout  = r_timeout;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_ddio_in_capture_ctrl.sv
// Scoreboard bench for ddio_in_capture_ctrl: one drop-on-full and one stall-on-full
// instance, each fed by a small model of the DDIO atoms.
module tb_ddio_in_capture_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        a_en, a_clkena, a_valid, a_ready, a_locked, a_swapped, a_timeout, a_overflow;
    logic [7:0]  a_h, a_l;
    logic [63:0] a_data;
    logic        b_en, b_clkena, b_valid, b_ready, b_locked, b_swapped, b_timeout, b_overflow;
    logic [7:0]  b_h, b_l;
    logic [63:0] b_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] a_src[$];
    logic [15:0] b_src[$];
    logic [63:0] a_exp[$];
    logic [63:0] b_exp[$];

    ddio_in_capture_ctrl #(
        .DATA_WIDTH(8), .WORD_BEATS(4), .SYNC_PATTERN(16'hA55A),
        .SYNC_TIMEOUT(8), .STALL_ON_FULL(1'b0)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .enable(a_en), .ddio_clkena(a_clkena),
        .ddio_h(a_h), .ddio_l(a_l), .word_data(a_data), .word_valid(a_valid),
        .word_ready(a_ready), .locked(a_locked), .swapped(a_swapped),
        .timeout(a_timeout), .overflow(a_overflow)
    );

    ddio_in_capture_ctrl #(
        .DATA_WIDTH(8), .WORD_BEATS(4), .SYNC_PATTERN(16'hA55A),
        .SYNC_TIMEOUT(8), .STALL_ON_FULL(1'b1)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .enable(b_en), .ddio_clkena(b_clkena),
        .ddio_h(b_h), .ddio_l(b_l), .word_data(b_data), .word_valid(b_valid),
        .word_ready(b_ready), .locked(b_locked), .swapped(b_swapped),
        .timeout(b_timeout), .overflow(b_overflow)
    );

    // Atom model: an enabled edge captures the next {l,h} pair and presents it after the edge.
    always @(posedge clk) begin
        if (a_clkena) begin
            if (a_src.size() > 0) {a_l, a_h} <= a_src.pop_front();
            else                  {a_l, a_h} <= 16'h0000;
        end
        if (b_clkena) begin
            if (b_src.size() > 0) {b_l, b_h} <= b_src.pop_front();
            else                  {b_l, b_h} <= 16'h0000;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitors: every accepted word must be the next expected one.
    always @(negedge clk) begin
        if (reset_n && a_valid && a_ready) begin
            if (a_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL a_unexpected_word: got %h, required no word", a_data);
            end else begin
                check("a_word", a_data, a_exp.pop_front());
            end
        end
        if (reset_n && b_valid && b_ready) begin
            if (b_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL b_unexpected_word: got %h, required no word", b_data);
            end else begin
                check("b_word", b_data, b_exp.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_en = 1'b0; b_en = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        a_src.delete(); b_src.delete();
        a_exp.delete(); b_exp.delete();
    endtask

    task automatic load_word(input bit sel, input logic [63:0] w, input bit expect_it);
        for (int b = 0; b < 4; b++) begin
            if (sel) b_src.push_back(w[b*16 +: 16]);
            else     a_src.push_back(w[b*16 +: 16]);
        end
        if (expect_it) begin
            if (sel) b_exp.push_back(w);
            else     a_exp.push_back(w);
        end
    endtask

    task automatic drain(input bit sel, input string name);
        int k;
        k = 0;
        while (((sel ? b_exp.size() : a_exp.size()) != 0) && k < 200) begin
            tick(1);
            k++;
        end
        n_checks++;
        if ((sel ? b_exp.size() : a_exp.size()) != 0) begin
            n_errors++;
            $display("FAIL %s: %0d words still pending, required 0",
                     name, sel ? b_exp.size() : a_exp.size());
        end
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_clkena"},   a_clkena,   64'd0);
        check({tag, "_valid"},    a_valid,    64'd0);
        check({tag, "_locked"},   a_locked,   64'd0);
        check({tag, "_swapped"},  a_swapped,  64'd0);
        check({tag, "_timeout"},  a_timeout,  64'd0);
        check({tag, "_overflow"}, a_overflow, 64'd0);
        check({tag, "_data"},     a_data,     64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1);
    end

    initial begin
        a_h = '0; a_l = '0; b_h = '0; b_l = '0;
        a_en = 1'b0; b_en = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        reset_n = 1'b0;
        tick(2);
        check_a_zero("rst");
        check("rst_b_clkena", b_clkena, 64'd0);
        check("rst_b_valid",  b_valid,  64'd0);
        do_reset();

        // Normal lock: sync h=5A l=A5, then one word
        a_src.push_back(16'hA55A);
        load_word(1'b0, 64'h7766_5544_3322_1100, 1'b1);
        a_en = 1'b1;
        tick(7);
        check("t1_valid",   a_valid,   64'd1);
        check("t1_data",    a_data,    64'h7766_5544_3322_1100);
        check("t1_locked",  a_locked,  64'd1);
        check("t1_swapped", a_swapped, 64'd0);
        a_en = 1'b0;
        tick(1);
        check("t1_valid_one_cycle", a_valid,  64'd0);
        check("t1_unlock",          a_locked, 64'd0);
        tick(1);
        check("t1_clkena_off", a_clkena, 64'd0);
        drain(1'b0, "t1_drain");

        // Swapped lock: l=5A then h=A5 one sample later
        do_reset();
        a_src.push_back(16'h5A00);
        a_src.push_back(16'h00A5);
        foreach (a_src[i]) begin end
        a_src.push_back(16'h1122); a_src.push_back(16'h3344);
        a_src.push_back(16'h5566); a_src.push_back(16'h7788);
        a_src.push_back(16'h99AA); a_src.push_back(16'hBBCC);
        a_src.push_back(16'hDDEE); a_src.push_back(16'hFF10);
        a_exp.push_back(64'h8855_6633_4411_2200);
        a_exp.push_back(64'h10DD_EEBB_CC99_AA77);
        a_en = 1'b1;
        tick(3);
        check("t2_not_yet_locked", a_locked, 64'd0);
        tick(1);
        check("t2_locked",  a_locked,  64'd1);
        check("t2_swapped", a_swapped, 64'd1);
        drain(1'b0, "t2_drain");
        a_en = 1'b0;

        // Timeout: h kept below 8'h40 so neither pairing can match
        do_reset();
        for (int i = 0; i < 20; i++) a_src.push_back({8'($urandom), 2'b00, 6'($urandom)});
        a_en = 1'b1;
        for (int k = 0; k < 19; k++) begin
            tick(1);
            check($sformatf("t3_timeout_e%0d", k), a_timeout, (k == 9 || k == 17) ? 64'd1 : 64'd0);
            check($sformatf("t3_locked_e%0d", k),  a_locked,  64'd0);
        end
        a_en = 1'b0;

        // Overflow: three words with the consumer stalled
        do_reset();
        a_ready = 1'b0;
        a_src.push_back(16'hA55A);
        load_word(1'b0, 64'h0404_0303_0202_0101, 1'b1);
        load_word(1'b0, 64'h1414_1313_1212_1111, 1'b1);
        load_word(1'b0, 64'h2424_2323_2222_2121, 1'b0);
        a_en = 1'b1;
        tick(14);
        check("t4_no_overflow_yet", a_overflow, 64'd0);
        tick(1);
        check("t4_overflow", a_overflow, 64'd1);
        check("t4_head_valid", a_valid, 64'd1);
        check("t4_head_data",  a_data,  64'h0404_0303_0202_0101);
        a_en = 1'b0;
        tick(3);
        check("t4_overflow_cleared_idle", a_overflow, 64'd0);
        a_ready = 1'b1;
        drain(1'b0, "t4_drain");
        tick(8);
        check("t4_third_absent", a_valid, 64'd0);

        // Stall: same traffic on the flow-controlled instance
        do_reset();
        b_ready = 1'b0;
        b_src.push_back(16'hA55A);
        load_word(1'b1, 64'h0404_0303_0202_0101, 1'b1);
        load_word(1'b1, 64'h1414_1313_1212_1111, 1'b1);
        load_word(1'b1, 64'h2424_2323_2222_2121, 1'b1);
        b_en = 1'b1;
        tick(10);
        check("t5_clkena_before_full", b_clkena, 64'd1);
        tick(1);
        check("t5_clkena_full", b_clkena, 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check($sformatf("t5_clkena_held_%0d", k), b_clkena,   64'd0);
            check($sformatf("t5_no_overflow_%0d", k), b_overflow, 64'd0);
            check($sformatf("t5_head_%0d", k),        b_data,     64'h0404_0303_0202_0101);
        end
        b_ready = 1'b1;
        drain(1'b1, "t5_drain");
        check("t5_no_overflow_end", b_overflow, 64'd0);
        b_en = 1'b0;

        // Abort after two beats, then re-enable
        do_reset();
        a_src.push_back(16'hA55A);
        a_src.push_back(16'hC0C0);
        a_src.push_back(16'hC1C1);
        a_en = 1'b1;
        tick(5);
        check("t6_locked", a_locked, 64'd1);
        a_en = 1'b0;
        tick(1);
        check("t6_abort_locked",  a_locked,  64'd0);
        check("t6_abort_swapped", a_swapped, 64'd0);
        tick(1);
        check("t6_abort_clkena", a_clkena, 64'd0);
        a_src.delete();
        a_src.push_back(16'hA55A);
        load_word(1'b0, 64'hD3D3_D2D2_D1D1_D0D0, 1'b1);
        a_en = 1'b1;
        tick(2);
        check("t6_rehunt_unlocked", a_locked, 64'd0);
        drain(1'b0, "t6_drain");
        a_en = 1'b0;
        tick(2);

        // Reset mid-CAPTURE with a word still buffered
        a_ready = 1'b0;
        a_src.delete();
        a_src.push_back(16'hA55A);
        load_word(1'b0, 64'h4444_3333_2222_1111, 1'b0);
        a_src.push_back(16'h5555);
        a_src.push_back(16'h6666);
        a_en = 1'b1;
        tick(9);
        check("t6_buffered_valid", a_valid,  64'd1);
        check("t6_capture_locked", a_locked, 64'd1);
        reset_n = 1'b0;
        tick(1);
        check_a_zero("t6_rst");
        a_en = 1'b0;
        tick(1);
        reset_n = 1'b1;
        a_ready = 1'b1;
        tick(10);
        check("t6_no_word_after_reset", a_valid, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ddio_in_capture_ctrl.md
Name: ddio_in_capture_ctrl

Overview:
- Sequencer for a bank of DATA_WIDTH DDR input capture atoms (Stratix DDIO-in, no async reset).
- Drives the atoms' shared clock enable, hunts for a sync pattern, and determines the DDR edge pairing (normal, or half-cycle swapped).
- Assembles WORD_BEATS aligned beats into one word and delivers it through a 2-entry valid/ready output buffer.
- Sits between the pad-side DDIO atoms and the core-side consumer.

Parameters:
- DATA_WIDTH, 8, number of DDIO lanes (bits per edge).
- WORD_BEATS, 4, beats per output word; one beat is 2*DATA_WIDTH bits. Legal range 2..16.
- SYNC_PATTERN, 16'hA55A, beat value marking alignment. Width is 2*DATA_WIDTH; the first-captured sample is in the low half.
- SYNC_TIMEOUT, 1024, number of HUNT sample cycles without a match before timeout is pulsed. Must be ≥1.
- STALL_ON_FULL, 0. 1 = drop ddio_clkena while the buffer is full (flow-controlled source). 0 = keep capturing and drop words.

Ports:
- clk, input, 1: sole clock; also clocks the DDIO atoms.
- reset_n, input, 1: synchronous, active-low reset.
- enable, input, 1: level-sensitive. 1 = run; 0 = return to IDLE.
- ddio_clkena, output, 1: to the atoms' clkena.
- ddio_h, input, DATA_WIDTH: from the atoms' dataout_h (rising-edge sample).
- ddio_l, input, DATA_WIDTH: from the atoms' dataout_l (falling-edge sample).
- word_data, output, 2*DATA_WIDTH*WORD_BEATS: assembled word; beat 0 in the LSBs.
- word_valid, output, 1: word_data valid.
- word_ready, input, 1: consumer accepts the word when valid & ready.
- locked, output, 1: sync found; word assembly is active.
- swapped, output, 1: alignment uses the swapped pairing.
- timeout, output, 1: 1-cycle pulse on HUNT timeout.
- overflow, output, 1: sticky; a word was dropped. Cleared by reset or by IDLE entry.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE.
  - ddio_clkena, word_valid, locked, swapped, timeout, overflow all 0.
  - word_data=0.
  - Buffer is emptied, all counters are 0, and the previous-sample register is invalid.
- Sample validity: samp_v = ddio_clkena registered by 1 cycle, because the atoms present data one clk after an enabled edge. Only cycles with samp_v=1 are processed.
- Normal pairing: beat = {l_n, h_n}.
- Swapped pairing: beat = {h_n, l_{n-1}}. l_{n-1} is the previous valid ddio_l, held in a register.
- States:
  - IDLE: ddio_clkena=0. When enable=1, go to HUNT; ddio_clkena=1 from the next cycle.
  - HUNT: each samp_v cycle, test both pairings against SYNC_PATTERN.
    - Normal match has priority: go to CAPTURE with swapped=0.
    - Otherwise, a swapped match (requires a valid previous l): go to CAPTURE with swapped=1.
    - locked=1 from the cycle after the match.
    - The sync beat itself is not stored.
    - If SYNC_TIMEOUT samp_v cycles pass without a match: pulse timeout for 1 cycle, clear the counter, stay in HUNT.
  - CAPTURE: each samp_v cycle, shift the selected beat into slot beat_cnt; beat_cnt counts 0..WORD_BEATS-1 and wraps.
    - On the last beat, push the word into the buffer.
    - A sync-pattern beat inside CAPTURE is ordinary data.
- enable=0 in any state:
  - Next state IDLE; ddio_clkena=0 next cycle; locked=0 and swapped=0.
  - The partial word is discarded.
  - Buffered complete words are still drained.
  - overflow is cleared on IDLE entry.
- Output buffer: 2 entries, FIFO order; word_data/word_valid come from the head entry.
  - Push and pop in the same cycle are always legal, including when the buffer is full.
  - Push while full with no pop, STALL_ON_FULL=0: the new word is dropped and overflow is set (sticky).
  - STALL_ON_FULL=1: ddio_clkena=0 in any cycle where the buffer is full and word_ready=0. The resulting gap in samp_v pauses assembly without loss.
- Latency: last DDIO sample of a word (samp_v cycle) → word_valid=1 on the next cycle when the buffer was empty.
- Throughput: 1 word per WORD_BEATS cycles.
- Simultaneous events: enable=0 in the same cycle as a last-beat push → the push is discarded. reset_n dominates everything.

Decomposition:
- Shared package ddio_ctrl_pkg:
  - State enum (IDLE, HUNT, CAPTURE).
  - Beat-width and word-width localparam functions.
  - Counter width function clog2.
- One sub-module: ddio_word_skid_buf, the 2-entry valid/ready buffer with a full flag and a drop output.
- Assembly and the FSM remain in the top level.

Test Plan:
1. Normal lock:
   - Stimulus: enable=1, h=5A/l=A5 on one samp_v cycle, then beats 0x1100,0x3322,0x5544,0x7766; word_ready=1.
   - Required: locked=1, swapped=0, word_data=0x7766554433221100, word_valid=1 for 1 cycle, 1 cycle after the last beat.
2. Swapped lock:
   - Stimulus: l=5A in cycle n, h=A5 in cycle n+1, no normal match.
   - Required: swapped=1; subsequent words are paired {h_n, l_{n-1}} and match the expected interleave.
3. Timeout:
   - Stimulus: SYNC_TIMEOUT=8, random data with no match.
   - Required: timeout pulses at samp_v counts 8 and 16; locked stays 0.
4. Overflow:
   - Stimulus: STALL_ON_FULL=0, word_ready=0 for 3 words.
   - Required: 2 words are held (first at the head); overflow=1 after the 3rd word; the 3rd word is absent after draining.
5. Stall:
   - Stimulus: STALL_ON_FULL=1, same stimulus as scenario 4.
   - Required: ddio_clkena=0 while the buffer is full; no overflow; all words are received in order after word_ready=1.
6. Abort and reset:
   - Stimulus: enable=0 after 2 beats of a word, then re-enable; also reset_n=0 mid-CAPTURE.
   - Required: the partial word is never output; HUNT restarts; after reset all outputs are 0 on the next cycle.
